// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory buses of the two-port memory arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ready;
    logic [15:0] if_data;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        err;
    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        output if_ready, if_data, d_ready, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, err
    );
    modport master (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        input  if_ready, if_data, d_ready, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority fetch/data arbiter onto one memory port; MEM_ARBITER_ANTI_STARVE_EN enables fetch starvation protection
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    if (STARVE_LIMIT < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_arbiter: STARVE_LIMIT and TIMEOUT must be >= 1 (SW=%0d)", SW);
    end
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic sel_q, sel_d, to_q, to_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [15:0] rd_q, rd_d;
    logic if_ready_q, if_ready_d, d_ready_q, d_ready_d, err_q, err_d;
    logic mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [15:0] if_data_q, if_data_d, d_rdata_q, d_rdata_d;
    logic starve, take_d;
`ifdef MEM_ARBITER_ANTI_STARVE_EN
    logic [SW-1:0] sc_q, sc_d;
    // consecutive data grants while a fetch waits; forces a fetch grant at the limit
    always_comb begin
        starve = bus.if_req && sc_q == SW'(STARVE_LIMIT);
        sc_d = !bus.if_req ? '0
             : (state_q == IDLE && (bus.if_req || bus.d_req)) ? (take_d ? sc_q + 1'b1 : '0)
             : sc_q;
    end
    // starvation counter register
    always_ff @(posedge clk) sc_q <= rst ? '0 : sc_d;
`else
    assign starve = 1'b0;
`endif
    // arbitration FSM: grant, issue one strobe, wait for memory or timeout, respond
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        to_d        = to_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = 1'b0;
        take_d      = bus.d_req && !starve;
        case (state_q)
            IDLE: if (bus.if_req || bus.d_req) begin
                sel_d       = take_d;
                mem_wr_d    = take_d && bus.d_wr;
                mem_addr_d  = take_d ? bus.d_addr : bus.if_addr;
                mem_wdata_d = take_d ? bus.d_wdata : '0;
                mem_en_d    = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.mem_valid) begin
                rd_d    = bus.mem_rdata;
                to_d    = 1'b0;
                state_d = RESP;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                to_d    = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: begin
                if_ready_d = !sel_q;
                d_ready_d  = sel_q;
                err_d      = to_q;
                if_data_d  = (!to_q && !sel_q) ? rd_q : if_data_q;
                d_rdata_d  = (!to_q && sel_q && !mem_wr_q) ? rd_q : d_rdata_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            to_q        <= 1'b0;
            cnt_q       <= '0;
            rd_q        <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            to_q        <= to_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
        end
    end
    assign bus.if_ready  = if_ready_q;
    assign bus.if_data   = if_data_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a 3-cycle XOR memory model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_arbiter_if bus();
    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [2:0]  sr = '0;
    logic [15:0] maddr = '0;
    logic        mem_off = 1'b0;
    // memory model: completion 3 cycles after the strobe, data = address ^ A5A5; not reset by rst
    always @(posedge clk) begin
        sr <= {sr[1:0], bus.mem_en & ~mem_off};
        if (bus.mem_en) maddr <= bus.mem_addr;
    end
    assign bus.mem_valid = sr[2];
    assign bus.mem_rdata = maddr ^ 16'hA5A5;
    int n_chk = 0, n_pass = 0, cyc = 0;
    int en_cnt, en_cyc, rdy_cyc, t0;
    logic en_wr, seen, bad, fetch_g;
    logic [15:0] en_addr, en_wdata, exp_if;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask
    task automatic wait_rdy();
        en_cnt  = 0;
        rdy_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.mem_en) begin
                en_cnt++;
                en_cyc   = cyc;
                en_wr    = bus.mem_wr;
                en_addr  = bus.mem_addr;
                en_wdata = bus.mem_wdata;
            end
            if (bus.if_ready || bus.d_ready) begin
                rdy_cyc = cyc;
                chk("ready_excl", {31'd0, bus.if_ready & bus.d_ready}, 0);
                break;
            end
        end
        if (rdy_cyc < 0) chk("ready_bound", 0, 1);
    endtask
    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0;
        step();
        step();
        chk("rst_strobes", {27'd0, bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_wr, bus.err}, 0);
        chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_rdata", {bus.if_data, bus.d_rdata}, 0);
        rst = 0;
        // fetch only
        bus.if_req = 1; bus.if_addr = 16'h0010; t0 = cyc;
        wait_rdy();
        chk("f_latency", rdy_cyc - t0, 6);
        chk("f_en_count", en_cnt, 1);
        chk("f_en_cycle", en_cyc - t0, 1);
        chk("f_mem_wr", {31'd0, en_wr}, 0);
        chk("f_mem_addr", {16'd0, en_addr}, 16'h0010);
        chk("f_if_ready", {31'd0, bus.if_ready}, 1);
        chk("f_if_data", {16'd0, bus.if_data}, 16'hA5B5);
        chk("f_err", {31'd0, bus.err}, 0);
        bus.if_req = 0;
        step();
        chk("f_pulse", {31'd0, bus.if_ready}, 0);
        // simultaneous data read and fetch
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0100; bus.if_req = 1; bus.if_addr = 16'h0002;
        wait_rdy();
        chk("s_d_first", {30'd0, bus.d_ready, bus.if_ready}, 2);
        chk("s_d_rdata", {16'd0, bus.d_rdata}, 16'hA4A5);
        bus.d_req = 0; t0 = cyc;
        wait_rdy();
        chk("s_if_grant", en_cyc - t0, 1);
        chk("s_if_latency", rdy_cyc - t0, 6);
        chk("s_if_data", {16'd0, bus.if_data}, 16'hA5A7);
        chk("s_d_hold", {16'd0, bus.d_rdata}, 16'hA4A5);
        bus.if_req = 0;
        // data write
        step();
        bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1234;
        wait_rdy();
        chk("w_mem_wr", {31'd0, en_wr}, 1);
        chk("w_mem_addr", {16'd0, en_addr}, 16'h0200);
        chk("w_mem_wdata", {16'd0, en_wdata}, 16'h1234);
        chk("w_d_ready", {31'd0, bus.d_ready}, 1);
        chk("w_d_rdata", {16'd0, bus.d_rdata}, 16'hA4A5);
        bus.d_req = 0; bus.d_wr = 0;
        step();
        chk("w_pulse", {31'd0, bus.d_ready}, 0);
        // starvation: both requests held for five grants
        bus.d_req = 1; bus.d_addr = 16'h0300; bus.if_req = 1; bus.if_addr = 16'h0004;
        for (int g = 0; g < 5; g++) begin
            wait_rdy();
`ifdef MEM_ARBITER_ANTI_STARVE_EN
            fetch_g = (g == 4);
`else
            fetch_g = 1'b0;
`endif
            chk($sformatf("starve_g%0d", g), {31'd0, bus.if_ready}, {31'd0, fetch_g});
        end
        bus.d_req = 0; bus.if_req = 0;
        // timeout: memory never answers
        step();
        mem_off = 1;
        bus.if_req = 1; bus.if_addr = 16'h0020; t0 = cyc;
        wait_rdy();
`ifdef MEM_ARBITER_ANTI_STARVE_EN
        exp_if = 16'hA5A1;
`else
        exp_if = 16'hA5A7;
`endif
        chk("t_latency", rdy_cyc - t0, 11);
        chk("t_err", {30'd0, bus.err, bus.if_ready}, 3);
        chk("t_if_data", {16'd0, bus.if_data}, {16'd0, exp_if});
        bus.if_req = 0;
        mem_off = 0;
        step();
        chk("t_err_pulse", {31'd0, bus.err}, 0);
        // reset during WAIT, late completion must be ignored
        bus.d_req = 1; bus.d_addr = 16'h0400;
        step();
        chk("r_issue", {31'd0, bus.mem_en}, 1);
        step();
        rst = 1; bus.d_req = 0;
        step();
        chk("r_strobes", {27'd0, bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_wr, bus.err}, 0);
        chk("r_mem_bus", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("r_rdata", {bus.if_data, bus.d_rdata}, 0);
        rst = 0;
        seen = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen |= bus.mem_valid;
            bad  |= bus.if_ready | bus.d_ready | bus.mem_en;
        end
        chk("r_late_valid_seen", {31'd0, seen}, 1);
        chk("r_no_activity", {31'd0, bad}, 0);
        // normal operation after reset
        bus.if_req = 1; bus.if_addr = 16'h0010; t0 = cyc;
        wait_rdy();
        chk("p_latency", rdy_cyc - t0, 6);
        chk("p_if_data", {16'd0, bus.if_data}, 16'hA5B5);
        bus.if_req = 0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
